// File: rtl/suma_acumulada_sat.sv
// Serial saturating accumulator: sums a first/last framed burst of signed terms and
// emits one registered result per frame through a valid/ready output stage.
module suma_acumulada_sat #(
  parameter int unsigned Width    = 25,
  parameter int unsigned MaxTerms = 16,
  parameter bit          SatEn    = 1'b1,
  parameter int unsigned CntW     = $clog2(MaxTerms + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic             out_sat,
  output logic [CntW-1:0]  out_count,
  output logic             out_err
);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  localparam logic [Width-1:0] MaxV   = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0] MinV   = {1'b1, {(Width-1){1'b0}}};
  localparam logic [CntW-1:0]  CntMax = {CntW{1'b1}};
  localparam logic [CntW-1:0]  Limit  = CntW'(MaxTerms);

  state_e           state_q, state_d;
  logic [Width-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sat_q, sat_d, err_q, err_d, pend_q, pend_d;
  logic             ov_q, ov_d;
  logic [Width-1:0] od_q, od_d;
  logic [CntW-1:0]  oc_q, oc_d;
  logic             os_q, os_d, oe_q, oe_d;

  logic             accept, frame_done, ovf;
  logic [Width:0]   sum;
  logic [Width-1:0] acc_nxt;
  logic [CntW-1:0]  cnt_inc;

  assign in_ready = ~ov_q | out_ready;
  assign accept   = in_valid & in_ready & ~clr;

  // Sign-extended add; overflow iff operands agree in sign and the result does not.
  assign sum     = {acc_q[Width-1], acc_q} + {in_data[Width-1], in_data};
  assign ovf     = (acc_q[Width-1] == in_data[Width-1]) && (sum[Width-1] != acc_q[Width-1]);
  assign acc_nxt = (SatEn && ovf) ? (acc_q[Width-1] ? MinV : MaxV) : sum[Width-1:0];
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    err_d      = err_q;
    pend_d     = pend_q;
    frame_done = 1'b0;
    if (clr) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
      err_d   = 1'b0;
      pend_d  = 1'b0;
    end else if (accept) begin
      if (in_first) begin
        // A first while accumulating abandons the partial frame.
        acc_d   = in_data;
        cnt_d   = CntW'(1);
        sat_d   = 1'b0;
        err_d   = pend_q | (state_q == StAcc);
        pend_d  = 1'b0;
        state_d = StAcc;
      end else if (state_q == StAcc) begin
        acc_d = acc_nxt;
        cnt_d = cnt_inc;
        sat_d = sat_q | ovf;
        err_d = err_q | (cnt_inc > Limit);
      end else begin
        pend_d = 1'b1;
      end
      frame_done = in_last & (in_first | (state_q == StAcc));
      if (frame_done) state_d = StIdle;
    end
  end

  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    os_d = os_q;
    oc_d = oc_q;
    oe_d = oe_q;
    if (frame_done) begin
      ov_d = 1'b1;
      od_d = acc_d;
      os_d = sat_d;
      oc_d = cnt_d;
      oe_d = err_d;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      os_q    <= 1'b0;
      oc_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      os_q    <= os_d;
      oc_q    <= oc_d;
      oe_q    <= oe_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_sat   = os_q;
  assign out_count = oc_q;
  assign out_err   = oe_q;

endmodule

// File: tb/tb_suma_acumulada_sat.sv
// Bench for suma_acumulada_sat: saturating and wrapping instances share one stimulus
// stream; a frame-level reference model feeds per-instance scoreboards.
module tb_suma_acumulada_sat;
  localparam int W    = 8;
  localparam int CW   = 5;
  localparam int MaxT = 16;

  logic clk = 1'b0, reset_n = 1'b1, clr = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic ir_a, ov_a, os_a, oe_a, ir_b, ov_b, os_b, oe_b;
  logic [W-1:0] od_a, od_b;
  logic [CW-1:0] oc_a, oc_b;

  suma_acumulada_sat #(.Width(W), .MaxTerms(MaxT), .SatEn(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(ir_a),
    .in_first(in_first), .in_last(in_last), .in_data(in_data), .out_valid(ov_a),
    .out_ready(out_ready), .out_data(od_a), .out_sat(os_a), .out_count(oc_a), .out_err(oe_a)
  );
  suma_acumulada_sat #(.Width(W), .MaxTerms(MaxT), .SatEn(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(ir_b),
    .in_first(in_first), .in_last(in_last), .in_data(in_data), .out_valid(ov_b),
    .out_ready(out_ready), .out_data(od_b), .out_sat(os_b), .out_count(oc_b), .out_err(oe_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  data;
    bit  sat;
    int  cnt;
    bit  err;
    time t;
  } exp_t;

  exp_t q[2][$];  // index 0: saturating instance, 1: wrapping instance
  int   checks = 0, failures = 0;
  bit   rdy_rand = 1'b0;
  bit   m_in_frame = 1'b0, m_pend = 1'b0, m_ferr = 1'b0;
  int   terms[$];
  bit   prv_v[2], prv_hs[2];

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Frame result from the accepted terms, with the range clamped or wrapped per step.
  function automatic exp_t fold(bit sat_mode);
    exp_t e;
    int acc, v, n;
    acc   = terms[0];
    e.sat = 1'b0;
    for (int i = 1; i < terms.size(); i++) begin
      v = acc + terms[i];
      if (v > 127 || v < -128) begin
        e.sat = 1'b1;
        if (sat_mode) acc = (v > 127) ? 127 : -128;
        else          acc = (v > 127) ? v - 256 : v + 256;
      end else begin
        acc = v;
      end
    end
    n     = terms.size();
    e.data = acc;
    e.cnt = (n > 31) ? 31 : n;
    e.err = m_ferr || (n > MaxT);
    e.t   = 0;
    return e;
  endfunction

  function automatic void model_accept(bit f, bit l, int d, time t);
    exp_t e;
    if (!m_in_frame && !f) begin
      m_pend = 1'b1;
      return;
    end
    if (f) begin
      m_ferr = m_in_frame || m_pend;
      m_pend = 1'b0;
      terms.delete();
      m_in_frame = 1'b1;
    end
    terms.push_back(d);
    if (l) begin
      for (int k = 0; k < 2; k++) begin
        e   = fold(k == 0);
        e.t = t;
        q[k].push_back(e);
      end
      m_in_frame = 1'b0;
    end
  endfunction

  function automatic void model_abort();
    m_in_frame = 1'b0;
    m_pend     = 1'b0;
    terms.delete();
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(bit f, bit l, int d);
    bit  ok;
    int  n;
    time t;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_data  = d[W-1:0];
    n  = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = ir_a;
      t  = $time;
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send timeout", 0, 1);
    else     model_accept(f, l, d, t);
    #1;
    in_valid = 1'b0;
  endtask

  // clr with an otherwise acceptable single-beat frame: the beat must be ignored.
  task automatic clr_pulse();
    clr      = 1'b1;
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last  = 1'b1;
    in_data  = 8'd99;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    model_abort();
  endtask

  task automatic rand_frame();
    int n, r;
    r = int'($urandom_range(0, 9));
    if (r == 0) send(1'b0, 1'($urandom_range(0, 1)), rnd());
    if (r == 1) begin
      send(1'b1, 1'b0, rnd());
      send(1'b0, 1'b0, rnd());
    end
    n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 18)) : int'($urandom_range(1, 6));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      if (r == 2 && n > 1 && i == n / 2) begin
        clr_pulse();
        return;
      end
      send(i == 0, i == n - 1, rnd());
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain pending results", q[0].size() + q[1].size(), 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " out_valid"}, {ov_a, ov_b}, 0);
    chk({tag, " out_data"}, {od_a, od_b}, 0);
    chk({tag, " out_sat"}, {os_a, os_b}, 0);
    chk({tag, " out_count"}, {oc_a, oc_b}, 0);
    chk({tag, " out_err"}, {oe_a, oe_b}, 0);
  endtask

  task automatic mon(int k, logic ir, logic ov, logic [W-1:0] od, logic os,
                     logic [CW-1:0] oc, logic oe);
    exp_t e;
    bit nw;
    chk($sformatf("in_ready[%0d]", k), ir, (!ov || out_ready));
    nw = ov && (!prv_v[k] || prv_hs[k]);
    if (ov) begin
      if (q[k].size() == 0) begin
        chk($sformatf("spurious out_valid[%0d]", k), 1, 0);
      end else begin
        e = q[k][0];
        chk($sformatf("out_data[%0d]", k), int'($signed(od)), e.data);
        chk($sformatf("out_sat[%0d]", k), os, e.sat);
        chk($sformatf("out_count[%0d]", k), oc, e.cnt);
        chk($sformatf("out_err[%0d]", k), oe, e.err);
        if (nw) chk($sformatf("latency[%0d]", k), $time, e.t + 10);
        if (out_ready) void'(q[k].pop_front());
      end
    end
    prv_v[k]  = ov;
    prv_hs[k] = ov && out_ready;
  endtask

  always @(negedge clk) begin
    mon(0, ir_a, ov_a, od_a, os_a, oc_a, oe_a);
    mon(1, ir_b, ov_b, od_b, os_b, oc_b, oe_b);
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1 reset_n = 1'b0;
    #2 chk_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("in_ready after reset", {ir_a, ir_b}, 2'b11);
    out_ready = 1'b1;

    send(1, 0, 10);   send(0, 0, 20);  send(0, 1, 30);
    send(1, 0, 100);  send(0, 0, 50);  send(0, 1, -30);
    send(1, 0, -100); send(0, 1, -50);
    send(1, 0, 100);  send(0, 1, 50);

    // Hold the single-beat result, then free it while the next last is accepted.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(1, 1, -5);
    repeat (3) begin
      @(negedge clk);
      chk("in_ready while held", {ir_a, ir_b}, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(1, 1, 9);

    send(0, 0, 7);  send(1, 0, 1);  send(0, 1, 2);
    send(1, 1, 5);
    send(1, 0, 50); send(0, 0, 60); send(1, 0, 3); send(0, 1, 4);
    for (int i = 0; i < 16; i++) send(i == 0, i == 15, 1);
    for (int i = 0; i < 17; i++) send(i == 0, i == 16, 1);
    for (int i = 0; i < 33; i++) send(i == 0, i == 32, -1);
    send(1, 0, 11); send(0, 0, 12); clr_pulse(); send(1, 0, 3); send(0, 1, 4);

    rdy_rand = 1'b1;
    repeat (60) rand_frame();
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    drain();

    send(1, 0, 20); send(0, 0, 30);
    @(negedge clk);
    reset_n = 1'b0;
    model_abort();
    #1 chk_zero("mid-frame reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no out_valid after reset", {ov_a, ov_b}, 0);
    end
    @(posedge clk);
    #1 send(1, 1, 42);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/suma_acumulada_sat.md
Name: suma_acumulada_sat

Overview:
- Serial saturating accumulator for the non-recursive filter datapath.
- Sums a framed burst of signed terms (one tap product per beat), delimited by first/last flags, and emits one registered result per frame.
- Generalises the combinational saturating adder with:
  - a selectable saturate/wrap mode
  - a sticky overflow flag
  - a term counter with a length limit
  - valid/ready handshaking on input and output

Parameters:
- Width, 25, two's-complement width of terms, accumulator and result.
- MaxTerms, 16, maximum legal terms per frame; exceeding it raises out_err.
- SatEn, 1, 1 = saturate at each addition; 0 = two's-complement wrap (overflow still flagged).
- CntW, clog2(MaxTerms+1), width of the term counter and out_count.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: drops any partial frame and returns to IDLE; does not affect a held output.
- in_valid  in  1  term present.
- in_ready  out  1  block can accept a term.
- in_first  in  1  term starts a frame.
- in_last  in  1  term ends a frame.
- in_data  in  Width  signed term.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  Width  signed frame sum.
- out_sat  out  1  at least one addition in the frame overflowed.
- out_count  out  CntW  number of terms accepted in the frame, saturating at 2^CntW-1.
- out_err  out  1  frame was malformed or too long.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State = IDLE; accumulator = 0; count = 0; sticky flags = 0.
  - out_valid=0, out_data=0, out_sat=0, out_count=0, out_err=0.
  - in_ready is 1 after reset deasserts.
- Limits: MAXV = 2^(Width-1)-1, MINV = -2^(Width-1).
- Sum rule: s = acc + in_data, computed at Width+1 bits.
  - Overflow when both operand signs are equal and the sign of s[Width-1:0] differs.
  - SatEn=1: positive overflow gives MAXV; negative overflow gives MINV.
  - SatEn=0: result = s[Width-1:0].
  - Later terms add to the saturated or wrapped value, not the true sum.
- Accept means in_valid & in_ready. in_ready = ~out_valid | out_ready, so the output register frees in the same cycle it is read.
- States:
  - IDLE:
    - Accept with first: acc=in_data, count=1, sat=0, err=0; go to ACC.
    - Accept without first: term dropped, err_pending=1, stay in IDLE. err_pending is ORed into the next frame's out_err.
  - ACC:
    - Accept without first: acc=sum rule, count+1, sat |= overflow.
    - Accept with first: abandon the partial frame, reload as in IDLE, set err=1.
  - Any accepted last, including first&last together:
    - Load out_data (final acc, including this term), out_sat, out_count and out_err; out_valid=1 on the next edge.
    - Go to IDLE.
    - first&last together gives out_data=in_data, out_count=1.
- Latency: one clock from accepting the last term to out_valid=1.
- Output hold: out_valid and the output fields stay stable until out_valid&out_ready. If a new last is accepted in that same cycle, the new result loads back-to-back with no bubble.
- out_err is set by any of:
  - count exceeding MaxTerms (counter saturates at 2^CntW-1)
  - abandoned frame (first received in ACC)
  - pending orphan term (err_pending)
- clr:
  - Forces IDLE, acc=0, count=0, flags=0 on the next edge.
  - An accept in the same cycle is ignored.
  - out_valid and the held output are kept.
- Simultaneous clr and out_ready: both take effect.
- Mid-frame reset: the partial sum is lost; no output is produced.

Test Plan:
- Width=8, SatEn=1. Frame 10, 20, 30 (last) -> out_data=60, out_sat=0, out_count=3, out_err=0; out_valid exactly 1 cycle after the last beat.
- Width=8, SatEn=1. Positive overflow, 100, 50, -30 -> 127-30 = 97, out_sat=1. Negative overflow, -100, -50 -> -128, out_sat=1.
- Width=8, SatEn=0. Frame 100, 50 -> out_data=-106, out_sat=1.
- Single-beat frame with first&last, in_data=-5 -> out_data=-5, out_count=1. Then out_ready=0 for 3 cycles: in_ready=0, output stable. Then out_ready=1 with the next frame's last accepted in the same cycle -> back-to-back results.
- Malformed frames:
  - Term without first in IDLE -> dropped; next frame has out_err=1.
  - first mid-frame -> new sum only, out_err=1.
  - 17 terms with MaxTerms=16 -> out_err=1.
- clr asserted mid-frame after 2 terms; new frame 3, 4 -> out_data=7, out_count=2. reset_n pulsed low mid-frame -> all outputs 0 immediately and no out_valid afterwards.
